// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer.
// in_ready comes from state and flush only, which cuts the upstream ready path.
module pipe_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire;
   logic             out_fire;

   assign in_ready  = !flush && (state_q != SKID);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      occupancy = 2'd0;
      unique case (state_q)
         EMPTY:   occupancy = 2'd0;
         FULL:    occupancy = 2'd1;
         SKID:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Data registers load only on an accepted beat, so idle X never lands
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = FULL;
                  main_d  = in_data;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = SKID;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a randomized run
// scored against a queue holding the entries the block should own.
module tb_pipe_skid_reg;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;

   int passed = 0;
   int total  = 0;
   logic [WIDTH-1:0] q[$];

   pipe_skid_reg #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and apply the same clock's effect to the reference queue
   task automatic tick();
      bit inf;
      bit outf;
      inf  = in_valid && !flush && (q.size() < 2);
      outf = out_ready && (q.size() > 0);
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(in_data);
         if (flush) q.delete();
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #2;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else passed++;
      total++; if (out_data !== '0) $display("FAIL rst_out_data: got %0h want 0", out_data); else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else passed++;
      // load two entries, then assert reset between edges
      in_valid = 1'b1; in_data = 32'h11; tick();
      in_data = 32'h22; tick();
      in_valid = 1'b0; #1;
      total++; if (occupancy !== 2'd2) $display("FAIL rst_preload_occ: got %0d want 2", occupancy); else passed++;
      #2; rst_n = 1'b0; #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %0b want 0", out_valid); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL rst_mid_occ: got %0d want 0", occupancy); else passed++;
      total++; if (out_data !== '0) $display("FAIL rst_mid_data: got %0h want 0", out_data); else passed++;
      q.delete();
      tick();
      rst_n = 1'b1; #1;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_rel_ready: got %0b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_rel_valid: got %0b want 0", out_valid); else passed++;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_data = WIDTH'(i); #1;
         total++; if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); else passed++;
         if (i > 1) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i - 1))
               $display("FAIL stream_data[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i - 1);
            else passed++;
         end
         tick();
      end
      in_valid = 1'b0; #1;
      total++; if (out_data !== 32'd10 || out_valid !== 1'b1) $display("FAIL stream_last: got v=%0b d=%0h want v=1 d=a", out_valid, out_data); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stream_drained: got %0b want 0", out_valid); else passed++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; tick();
      in_data = 32'hB; tick();
      in_valid = 1'b0; #1;
      total++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d want 2", occupancy); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready: got %0b want 0", in_ready); else passed++;
      total++; if (out_data !== 32'hA) $display("FAIL bp_head: got %0h want a", out_data); else passed++;
      out_ready = 1'b1; #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_indep: got %0b want 0", in_ready); else passed++;
      tick();
      total++; if (out_data !== 32'hB) $display("FAIL bp_second: got %0h want b", out_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %0b want 1", in_ready); else passed++;
      total++; if (occupancy !== 2'd1) $display("FAIL bp_occ_after: got %0d want 1", occupancy); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %0b want 0", out_valid); else passed++;
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h5; tick();
      in_data = 32'h6; out_ready = 1'b1; #1;
      total++; if (out_data !== 32'h5) $display("FAIL sim_before: got %0h want 5", out_data); else passed++;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; #1;
      total++; if (out_data !== 32'h6) $display("FAIL sim_data: got %0h want 6", out_data); else passed++;
      total++; if (occupancy !== 2'd1) $display("FAIL sim_occ: got %0d want 1", occupancy); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL sim_valid: got %0b want 1", out_valid); else passed++;
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1; tick();
      in_data = 32'h2; tick();
      flush = 1'b1; in_data = 32'h3; #1;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", in_ready); else passed++;
      total++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy); else passed++;
      tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_ready_after: got %0b want 1", in_ready); else passed++;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         in_data   = in_valid ? WIDTH'($urandom) : 'x;
         #1;
         total++;
         if (in_ready !== (!flush && q.size() < 2)) begin
            if (bad < 10) $display("FAIL rnd_ready@%0d: got %0b want %0b", c, in_ready, (!flush && q.size() < 2));
            bad++;
         end else passed++;
         total++;
         if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0)) begin
            if (bad < 10) $display("FAIL rnd_occ@%0d: got occ=%0d v=%0b want occ=%0d", c, occupancy, out_valid, q.size());
            bad++;
         end else passed++;
         if (q.size() > 0) begin
            total++;
            if (out_data !== q[0]) begin
               if (bad < 10) $display("FAIL rnd_data@%0d: got %0h want %0h", c, out_data, q[0]);
               bad++;
            end else passed++;
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_simultaneous();
      test_flush();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
